// File: rtl/pc_gen_if.sv
// pc_gen_if: bundles the fetch-stage control, redirect and instruction-memory
// signals of the program-counter generator.
//   master : control unit / decode / instruction memory side. It drives stall,
//            imem_ready, branch_flag, branch_target_addr, flush and new_pc,
//            and it receives pc, ce and misalign.
//   slave  : pc_gen itself. It receives the requests and drives pc, ce and
//            misalign.
// ADDR_W must match the ADDR_W of the pc_gen instance that is attached.
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              imem_ready;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target_addr;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              misalign;

  modport master (
    output stall, imem_ready, branch_flag, branch_target_addr, flush, new_pc,
    input  pc, ce, misalign
  );

  modport slave (
    input  stall, imem_ready, branch_flag, branch_target_addr, flush, new_pc,
    output pc, ce, misalign
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
// It produces the instruction-fetch address (pc) and the chip enable (ce) for
// instruction memory. It handles pipeline stall, memory back-pressure, branch
// redirect with a one-entry pending-redirect buffer, and exception flush.
// Ports:
//   clk  : system clock; all state changes on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : pc_gen_if slave modport
//          inputs  stall, imem_ready, branch_flag, branch_target_addr,
//                  flush, new_pc
//          outputs pc (fetch address), ce (chip enable), misalign (one-cycle
//                  pulse after a target with nonzero low bits was loaded)
// Every output comes from a register, so no input reaches an output
// combinationally.
module pc_gen #(
  parameter int          ADDR_W     = 32,
  parameter logic [63:0] RESET_VEC  = 64'd0,
  parameter int          INC        = 4,
  parameter int          ALIGN_BITS = 2
) (
  input  logic   clk,
  input  logic   rst,
  pc_gen_if.slave bus
);

  typedef enum logic [0:0] {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC   = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] INC_VAL    = ADDR_W'(INC);
  // Mask of the low address bits that must be zero. It is all zero when
  // ALIGN_BITS is 0, which also makes misalign constant 0.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] pend_addr_reg, pend_addr_next;
  logic              pend_valid_reg, pend_valid_next;
  logic              misalign_reg, misalign_next;
  logic              ce_out;

  logic              advance;
  logic [ADDR_W-1:0] branch_aligned;
  logic [ADDR_W-1:0] flush_aligned;
  logic              branch_bad;
  logic              flush_bad;

  assign advance        = bus.imem_ready & ~bus.stall;
  assign branch_aligned = bus.branch_target_addr & ~ALIGN_MASK;
  assign flush_aligned  = bus.new_pc & ~ALIGN_MASK;
  assign branch_bad     = (bus.branch_target_addr & ALIGN_MASK) != '0;
  assign flush_bad      = (bus.new_pc & ALIGN_MASK) != '0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: leaving reset always goes to S_RUN, and S_RUN is held
  // until the next reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_RESET;
    endcase
  end

  // Output logic: memory is enabled only while running.
  always_comb begin
    ce_out = 1'b0;
    if (state_reg == S_RUN) begin
      ce_out = 1'b1;
    end
  end

  // Next-PC selection and pending-redirect bookkeeping.
  always_comb begin
    pc_next         = pc_reg;
    pend_addr_next  = pend_addr_reg;
    pend_valid_next = pend_valid_reg;
    misalign_next   = 1'b0;

    if (state_reg == S_RESET) begin
      // Branches are ignored here. A flush can still place the handler
      // address before the first fetch.
      if (bus.flush) begin
        pc_next       = flush_aligned;
        misalign_next = flush_bad;
      end
    end else begin
      if (bus.flush) begin
        pc_next         = flush_aligned;
        pend_valid_next = 1'b0;
        misalign_next   = flush_bad;
      end else if (advance && bus.branch_flag) begin
        pc_next         = branch_aligned;
        pend_valid_next = 1'b0;
        misalign_next   = branch_bad;
      end else if (advance && pend_valid_reg) begin
        // The pending address was aligned and flagged when it was stored.
        pc_next         = pend_addr_reg;
        pend_valid_next = 1'b0;
      end else if (advance) begin
        pc_next = pc_reg + INC_VAL;
      end else if (bus.branch_flag) begin
        // A branch that arrives while fetch is held is kept until the next
        // advancing edge. A newer branch replaces an older one.
        pend_addr_next  = branch_aligned;
        pend_valid_next = 1'b1;
        misalign_next   = branch_bad;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg         <= RESET_PC;
      pend_addr_reg  <= '0;
      pend_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      pend_addr_reg  <= pend_addr_next;
      pend_valid_reg <= pend_valid_next;
      misalign_reg   <= misalign_next;
    end
  end

  assign bus.pc       = pc_reg;
  assign bus.ce       = ce_out;
  assign bus.misalign = misalign_reg;

endmodule
